// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field positions, FSM states.
// Build option ALU_ILLEGAL_TRAP_EN (see alu_seq) uses is_illegal_op below.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int AW     = 3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_PASX = 4'd8;
  localparam logic [3:0] OP_PASY = 4'd9;
  localparam logic [3:0] OP_LT   = 4'd10;
  localparam logic [3:0] OP_GT   = 4'd11;
  localparam logic [3:0] OP_EQ   = 4'd12;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_LO = 9;
  localparam int RS_LO = 6;
  localparam int RT_LO = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op > OP_EQ);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x8 register file: one synchronous write port, two operand read ports and a readback port.
// Synchronous active-low clear of every entry.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ra_x,
  input  logic [AW-1:0]     ra_y,
  input  logic [AW-1:0]     ra_rb,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_y,
  output logic [DATA_W-1:0] rd_rb
);

  logic [DATA_W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rd_x  = mem_q[ra_x];
  assign rd_y  = mem_q[ra_y];
  assign rd_rb = mem_q[ra_rb];

endmodule

// File: rtl/alu_seq.sv
// Sequencer driving an external combinational ALU: IDLE -> READ -> EXEC -> WB per instruction.
// Define ALU_ILLEGAL_TRAP_EN to trap opcodes 13..15 (IDLE -> WB, err pulse, no writeback).
//
// state | meaning
// IDLE  | accept preload or instruction
// READ  | register ctrl/x/y to the ALU
// EXEC  | ALU settles; capture out/carry
// WB    | write rd, pulse done (and err on trap)
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              flag_c,
  output logic              err
);

  state_e state_q, state_d;

  logic [3:0]        op_q;
  logic [AW-1:0]     rd_q, rs_q, rt_q;
  logic              trap_q;
  logic [3:0]        alu_ctrl_q;
  logic [DATA_W-1:0] alu_x_q, alu_y_q, res_q;
  logic              flag_c_q;

  logic              accept;
  logic              illegal_acc;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DATA_W-1:0] rf_wdata, rf_x, rf_y;
  logic              unused_instr;

  assign unused_instr = ^instr[2:0];

`ifdef ALU_ILLEGAL_TRAP_EN
  assign illegal_acc = is_illegal_op(instr[OP_HI:OP_LO]);
  assign err         = (state_q == WB) && trap_q;
`else
  assign illegal_acc = 1'b0;
  assign err         = 1'b0;
`endif

  assign in_ready = (state_q == IDLE) && !ld_en;
  assign accept   = in_valid && in_ready;
  assign done     = (state_q == WB);

  // Preload and writeback never coincide: preload is IDLE-only, writeback is WB-only.
  assign rf_we    = ((state_q == IDLE) && ld_en) || ((state_q == WB) && !trap_q);
  assign rf_waddr = (state_q == IDLE) ? ld_addr : rd_q;
  assign rf_wdata = (state_q == IDLE) ? ld_data : res_q;

  alu_regfile #(.DATA_W(DATA_W), .AW(AW)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .ra_x  (rs_q),
    .ra_y  (rt_q),
    .ra_rb (rb_addr),
    .rd_x  (rf_x),
    .rd_y  (rf_y),
    .rd_rb (rb_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = illegal_acc ? WB : READ;
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      trap_q     <= 1'b0;
      alu_ctrl_q <= '0;
      alu_x_q    <= '0;
      alu_y_q    <= '0;
      res_q      <= '0;
      flag_c_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        op_q   <= instr[OP_HI:OP_LO];
        rd_q   <= instr[RD_LO +: AW];
        rs_q   <= instr[RS_LO +: AW];
        rt_q   <= instr[RT_LO +: AW];
        trap_q <= illegal_acc;
      end
      if (state_q == READ) begin
        alu_ctrl_q <= op_q;
        alu_x_q    <= rf_x;
        alu_y_q    <= rf_y;
      end
      // Result is captured straight into res so it is valid while done is high.
      if (state_q == EXEC) begin
        res_q    <= alu_out;
        flag_c_q <= alu_carry;
      end
    end
  end

  assign alu_ctrl = alu_ctrl_q;
  assign alu_x    = alu_x_q;
  assign alu_y    = alu_y_q;
  assign res      = res_q;
  assign flag_c   = flag_c_q;

endmodule
